// File: rtl/dcache_pkg.sv
// Shared widths, FSM state encoding and address field helpers for the data cache controller.
package dcache_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int LINE_W  = 256;
   localparam int INDEX_W = 5;
   localparam int OFF_W   = 5;
   localparam int WSEL_W  = 3;
   localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
   localparam int LINES   = 1 << INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WB     = 2'd1,
      ST_REFILL = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[OFF_W +: INDEX_W];
   endfunction

   function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
      return addr[2 +: WSEL_W];
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage: asynchronous read, one synchronous write port
// that either installs a whole refilled line or updates a single word of a resident line.
module dcache_sram
   import dcache_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic [TAG_W-1:0]   rd_tag,
   output logic               rd_valid,
   output logic               rd_dirty,
   output logic [LINE_W-1:0]  rd_line,
   input  logic               wr_line_en,
   input  logic               wr_word_en,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_line,
   input  logic [WSEL_W-1:0]  wr_word_sel,
   input  logic [DATA_W-1:0]  wr_word
);

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [LINE_W-1:0] data_mem [LINES];
   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;

   assign rd_tag   = tag_mem[rd_idx];
   assign rd_line  = data_mem[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_line_en) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= 1'b0;
      end else if (wr_word_en) begin
         dirty_q[wr_idx] <= 1'b1;
      end
   end

   // Payload arrays carry no reset; the valid bits alone decide residency.
   always_ff @(posedge clk_i) begin
      if (wr_line_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_line;
      end else if (wr_word_en) begin
         data_mem[wr_idx][{wr_word_sel, 5'b0} +: DATA_W] <= wr_word;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller for the MEM stage.
// Optional DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o access counters.
//
// state  | meaning
// IDLE   | serve hits combinationally, detect misses
// WB     | write the dirty victim line back to memory
// REFILL | fetch the requested line from memory
// DONE   | one settle cycle, then IDLE sees the hit
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p1_req_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_data_i,
   output logic [DATA_W-1:0] p1_data_o,
   output logic              p1_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   state_t             state_q, state_d;
   logic [TAG_W-1:0]   lat_tag_q;
   logic [INDEX_W-1:0] lat_idx_q;

   logic [INDEX_W-1:0] rd_idx;
   logic [TAG_W-1:0]   rd_tag;
   logic               rd_valid, rd_dirty;
   logic [LINE_W-1:0]  rd_line;

   logic               wr_line_en, wr_word_en;
   logic [INDEX_W-1:0] wr_idx;

   logic               hit, idle_hit, ack_ok, miss_start;
   logic               addr_unused;

   assign addr_unused = ^p1_addr_i[1:0];

   // While a miss is in flight the arrays are addressed by the captured index.
   assign rd_idx   = (state_q == ST_IDLE) ? addr_index(p1_addr_i) : lat_idx_q;
   assign hit      = rd_valid && (rd_tag == addr_tag(p1_addr_i));
   assign idle_hit = (state_q == ST_IDLE) && hit;
   assign ack_ok   = mem_ack_i && mem_enable_o &&
                     ((state_q == ST_WB) || (state_q == ST_REFILL));
   assign miss_start = (state_q == ST_IDLE) && (state_d != ST_IDLE);

   dcache_sram u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rd_idx      (rd_idx),
      .rd_tag      (rd_tag),
      .rd_valid    (rd_valid),
      .rd_dirty    (rd_dirty),
      .rd_line     (rd_line),
      .wr_line_en  (wr_line_en),
      .wr_word_en  (wr_word_en),
      .wr_idx      (wr_idx),
      .wr_tag      (lat_tag_q),
      .wr_line     (mem_data_i),
      .wr_word_sel (addr_word(p1_addr_i)),
      .wr_word     (p1_data_i)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (p1_req_i && !hit) begin
               state_d = (rd_valid && rd_dirty) ? ST_WB : ST_REFILL;
            end
         end
         ST_WB:     if (ack_ok) state_d = ST_REFILL;
         ST_REFILL: if (ack_ok) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      p1_stall_o = p1_req_i && !idle_hit;
      p1_data_o  = idle_hit ? rd_line[{addr_word(p1_addr_i), 5'b0} +: DATA_W] : '0;
      wr_line_en = (state_q == ST_REFILL) && ack_ok;
      wr_word_en = idle_hit && p1_req_i && p1_write_i;
      wr_idx     = wr_line_en ? lat_idx_q : addr_index(p1_addr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lat_tag_q <= '0;
         lat_idx_q <= '0;
      end else if (miss_start) begin
         lat_tag_q <= addr_tag(p1_addr_i);
         lat_idx_q <= addr_index(p1_addr_i);
      end
   end

   // Memory-side outputs are registered, so the request trails state entry by one cycle
   // and is withdrawn the cycle after the ack.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
      end else begin
         mem_enable_o <= ((state_q == ST_WB) || (state_q == ST_REFILL)) && !ack_ok;
         mem_write_o  <= (state_q == ST_WB) && !ack_ok;
         if (state_q == ST_WB) begin
            mem_addr_o <= {rd_tag, lat_idx_q, {OFF_W{1'b0}}};
            mem_data_o <= rd_line;
         end else if (state_q == ST_REFILL) begin
            mem_addr_o <= {lat_tag_q, lat_idx_q, {OFF_W{1'b0}}};
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic prev_done_q;

   // The hit that retires a miss belongs to that miss and is not counted again.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_done_q <= 1'b0;
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
      end else begin
         prev_done_q <= (state_q == ST_DONE);
         if (p1_req_i && idle_hit && !prev_done_q) hit_cnt_o <= hit_cnt_o + 32'd1;
         if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed scenarios followed by random loads/stores
// checked against a line-level cache and memory model. Stats checks need DCACHE_STATS_EN.
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         p1_req_i, p1_write_i;
   logic [31:0]  p1_addr_i, p1_data_i;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt, miss_cnt;
`endif

   dcache_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .p1_req_i     (p1_req_i),
      .p1_write_i   (p1_write_i),
      .p1_addr_i    (p1_addr_i),
      .p1_data_i    (p1_data_i),
      .p1_data_o    (p1_data_o),
      .p1_stall_o   (p1_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt_o    (hit_cnt),
      .miss_cnt_o   (miss_cnt)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } mem_txn_t;

   int n_vec  = 0;
   int n_fail = 0;

   mem_txn_t     exp_mem[$];
   int           delay_q[$];
   int           exp_stall[$];
   logic [31:0]  exp_load[$];

   // reference model: cache contents per index and the memory behind it
   logic         m_valid [32];
   logic         m_dirty [32];
   logic [21:0]  m_tag   [32];
   logic [255:0] m_line  [32];
   logic [255:0] ref_mem [int unsigned];
   logic [255:0] bus_mem [int unsigned];
   int           m_hits = 0;
   int           m_miss = 0;

   logic resp_en   = 1'b1;
   logic force_ack = 1'b0;
   int   stall_cnt = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
   endtask

   function automatic logic [255:0] init_line(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = a ^ (32'h0101_0101 * (w + 1)) ^ 32'h5A00_0000;
      return l;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
         m_line[i]  = '0;
      end
      m_hits = 0;
      m_miss = 0;
   endtask

   // Called just after a posedge; returns just after the posedge that retires the access.
   task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      logic [4:0]   idx;
      logic [21:0]  tg;
      logic [2:0]   w;
      logic [31:0]  la;
      logic [255:0] ln;
      int           d, exp_st;
      bit           done;
      idx = addr[9:5];
      tg  = addr[31:10];
      w   = addr[4:2];
      if (m_valid[idx] && m_tag[idx] == tg) begin
         exp_st = 0;
         m_hits++;
      end else begin
         m_miss++;
         exp_st = 2;
         if (m_valid[idx] && m_dirty[idx]) begin
            la = {m_tag[idx], idx, 5'b0};
            exp_mem.push_back('{1'b1, la, m_line[idx]});
            ref_mem[la] = m_line[idx];
            d = int'($urandom_range(0, 3));
            delay_q.push_back(d);
            exp_st += d + 2;
         end
         la = {tg, idx, 5'b0};
         exp_mem.push_back('{1'b0, la, 256'h0});
         ln = ref_mem.exists(la) ? ref_mem[la] : init_line(la);
         d = int'($urandom_range(0, 3));
         delay_q.push_back(d);
         exp_st += d + 2;
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
         m_line[idx]  = ln;
      end
      if (wr) begin
         m_line[idx][{w, 5'b0} +: 32] = wdata;
         m_dirty[idx] = 1'b1;
      end else begin
         exp_load.push_back(m_line[idx][{w, 5'b0} +: 32]);
      end
      exp_stall.push_back(exp_st);

      p1_req_i   = 1'b1;
      p1_write_i = wr;
      p1_addr_i  = addr;
      p1_data_i  = wdata;
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk_i);
         if (!p1_stall_o) done = 1'b1;
      end
      if (!done) begin
         n_fail++;
         $display("FAIL access_timeout: addr %0h still stalled after 300 cycles", addr);
         summary();
         $finish;
      end
      @(posedge clk_i);
      #1;
      p1_req_i   = 1'b0;
      p1_write_i = 1'b0;
   endtask

   // scoreboard monitor: an access retires on a non-stalled requesting cycle
   always @(negedge clk_i) begin
      if (rst_i || !p1_req_i) begin
         stall_cnt = 0;
      end else if (p1_stall_o) begin
         stall_cnt++;
      end else begin
         if (exp_stall.size() == 0) begin
            chk("unexpected_retire", 256'(p1_addr_i), 256'h0);
         end else begin
            chk("stall_cycles", 256'(stall_cnt), 256'(exp_stall.pop_front()));
            if (!p1_write_i) begin
               if (exp_load.size() == 0) chk("unexpected_load", 256'(p1_data_o), 256'h0);
               else chk("load_data", 256'(p1_data_o), 256'(exp_load.pop_front()));
            end
         end
         stall_cnt = 0;
      end
   end

   // memory responder
   initial begin
      mem_txn_t     t;
      logic [255:0] line;
      int           d;
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         if (force_ack) begin
            mem_ack_i  = 1'b1;
            mem_data_i = {8{32'hBAD0_BAD0}};
            @(negedge clk_i);
            mem_ack_i  = 1'b0;
            mem_data_i = '0;
            force_ack  = 1'b0;
         end else if (resp_en && mem_enable_o) begin
            if (exp_mem.size() == 0) begin
               chk("unexpected_mem_req", 256'(mem_addr_o), 256'h0);
            end else begin
               t = exp_mem.pop_front();
               chk("mem_write", 256'(mem_write_o), 256'(t.wr));
               chk("mem_addr", 256'(mem_addr_o), 256'(t.addr));
               if (t.wr) chk("wb_data", mem_data_o, t.data);
            end
            if (mem_write_o) begin
               bus_mem[mem_addr_o] = mem_data_o;
               line = '0;
            end else begin
               line = bus_mem.exists(mem_addr_o) ? bus_mem[mem_addr_o] : init_line(mem_addr_o);
            end
            d = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
            repeat (d) @(negedge clk_i);
            mem_ack_i  = 1'b1;
            mem_data_i = line;
            @(negedge clk_i);
            mem_ack_i  = 1'b0;
            mem_data_i = '0;
         end
      end
   end

   initial begin
      #3_000_000;
      n_fail++;
      $display("FAIL global_timeout: simulation did not complete");
      summary();
      $finish;
   end

   initial begin
      logic [255:0] ln;
      logic [21:0]  tags [4];
      logic [31:0]  a;
      bit           got;
      tags[0] = 22'h0; tags[1] = 22'h1; tags[2] = 22'h2; tags[3] = 22'h3F_FFFF;

      rst_i      = 1'b1;
      p1_req_i   = 1'b0;
      p1_write_i = 1'b0;
      p1_addr_i  = '0;
      p1_data_i  = '0;
      model_reset();
      repeat (3) @(negedge clk_i);
      chk("rst_mem_enable", 256'(mem_enable_o), 256'h0);
      chk("rst_mem_write", 256'(mem_write_o), 256'h0);
      chk("rst_mem_addr", 256'(mem_addr_o), 256'h0);
      chk("rst_mem_data", mem_data_o, 256'h0);
      chk("rst_p1_data", 256'(p1_data_o), 256'h0);
      chk("rst_stall", 256'(p1_stall_o), 256'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // scenario 1: cold miss on 0x40, then a hit on the refilled word 2
      ln = init_line(32'h40);
      ln[95:64] = 32'hDEAD_BEEF;
      ref_mem[32'h40] = ln;
      bus_mem[32'h40] = ln;
      do_access(1'b0, 32'h0000_0040, 32'h0);
      do_access(1'b0, 32'h0000_0048, 32'h0);
      // scenario 2: store hit then load back
      do_access(1'b1, 32'h0000_0044, 32'h1234_5678);
      do_access(1'b0, 32'h0000_0044, 32'h0);
      // scenario 3: conflicting load forces write-back of the dirty line
      do_access(1'b0, 32'h0000_0440, 32'h0);
`ifdef DCACHE_STATS_EN
      chk("stats_miss_s123", 256'(miss_cnt), 256'd2);
      chk("stats_hit_s123", 256'(hit_cnt), 256'd3);
`endif
      // scenario 4: store miss allocates, later conflict writes it back
      do_access(1'b1, 32'h0000_0080, 32'hCAFE_F00D);
      do_access(1'b0, 32'h0000_0080, 32'h0);
      do_access(1'b0, 32'h0000_0480, 32'h0);

      // scenario 5: reset during refill, then a stray ack
      resp_en    = 1'b0;
      p1_req_i   = 1'b1;
      p1_write_i = 1'b0;
      p1_addr_i  = 32'h0000_0A60;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk_i);
         if (mem_enable_o) got = 1'b1;
      end
      chk("s5_refill_seen", 256'(got), 256'h1);
      chk("s5_refill_addr", 256'(mem_addr_o), 256'h0000_0A60);
      chk("s5_refill_write", 256'(mem_write_o), 256'h0);
      @(posedge clk_i);
      #1;
      rst_i    = 1'b1;
      p1_req_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("s5_enable_after_rst", 256'(mem_enable_o), 256'h0);
      chk("s5_stall_after_rst", 256'(p1_stall_o), 256'h0);
      force_ack = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("s5_enable_after_late_ack", 256'(mem_enable_o), 256'h0);
      chk("s5_write_after_late_ack", 256'(mem_write_o), 256'h0);
`ifdef DCACHE_STATS_EN
      chk("s5_stats_hit_cleared", 256'(hit_cnt), 256'h0);
      chk("s5_stats_miss_cleared", 256'(miss_cnt), 256'h0);
`endif
      model_reset();
      resp_en = 1'b1;
      @(posedge clk_i);
      #1;
      do_access(1'b0, 32'h0000_0A60, 32'h0);

      // random loads/stores over a few conflicting tags and indices
      for (int n = 0; n < 400; n++) begin
         a = {tags[$urandom_range(0, 3)], 5'($urandom_range(0, 4)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         do_access(1'($urandom_range(0, 1)), a, $urandom);
      end

      repeat (5) @(negedge clk_i);
      chk("mem_queue_drained", 256'(exp_mem.size()), 256'h0);
      chk("stall_queue_drained", 256'(exp_stall.size()), 256'h0);
      chk("load_queue_drained", 256'(exp_load.size()), 256'h0);
`ifdef DCACHE_STATS_EN
      chk("stats_hit_final", 256'(hit_cnt), 256'(m_hits));
      chk("stats_miss_final", 256'(miss_cnt), 256'(m_miss));
`endif
      summary();
      $finish;
   end

endmodule
